// File: rtl/mux2_arb_pkg.sv
// Shared encodings and defaults for the two-source round-robin burst arbiter.
// The optional grant statistics are enabled by the ARB_STATS_EN macro in mux2_arbiter.
package mux2_arb_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int MAX_BURST_DEF = 16;
   localparam int CNT_W         = 8;
   localparam int STATS_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/bus_sel2.sv
// Combinational 2:1 select of {data, last}; sel=0 picks source a, sel=1 picks source b.
module bus_sel2 #(
   parameter int DATA_W = 8
) (
   input  logic              sel,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_last,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,
   output logic [DATA_W-1:0] y_data,
   output logic              y_last
);

   always_comb begin
      y_data = sel ? b_data : a_data;
      y_last = sel ? b_last : a_last;
   end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin burst arbiter sharing one registered output bus between two sources.
// Define ARB_STATS_EN to add saturating per-source grant counters (grant0_cnt/grant1_cnt).
module mux2_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s0_valid,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_last,
   output logic              s0_ready,
   input  logic              s1_valid,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_last,
   output logic              s1_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              sel,
   output logic              busy,
   output logic [1:0]        dbg_state
`ifdef ARB_STATS_EN
   ,
   output logic [STATS_W-1:0] grant0_cnt,
   output logic [STATS_W-1:0] grant1_cnt
`endif
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   arb_state_e        state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_last_q, m_last_d;
   logic [DATA_W-1:0] mux_data;
   logic              mux_last;
   logic              own_valid, own_ready, accept, release_now;
   logic              grant0, grant1;

   bus_sel2 #(.DATA_W(DATA_W)) u_sel (
      .sel    (sel_q),
      .a_data (s0_data),
      .a_last (s0_last),
      .b_data (s1_data),
      .b_last (s1_last),
      .y_data (mux_data),
      .y_last (mux_last)
   );

   // A beat moves when valid and ready are both high at a rising edge; the owner
   // sees ready whenever the output register is empty or being drained.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_last_d    = m_last_q;
      s0_ready    = 1'b0;
      s1_ready    = 1'b0;
      grant0      = 1'b0;
      grant1      = 1'b0;
      own_valid   = sel_q ? s1_valid : s0_valid;
      own_ready   = !m_valid_q || m_ready;
      accept      = 1'b0;
      release_now = 1'b0;

      if (m_valid_q && m_ready) m_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s0_valid && (!s1_valid || !ptr_q)) begin
               state_d = ST_OWN0;
               sel_d   = 1'b0;
               grant0  = 1'b1;
            end else if (s1_valid) begin
               state_d = ST_OWN1;
               sel_d   = 1'b1;
               grant1  = 1'b1;
            end
         end
         ST_OWN0, ST_OWN1: begin
            s0_ready = (state_q == ST_OWN0) && own_ready;
            s1_ready = (state_q == ST_OWN1) && own_ready;
            accept   = own_valid && own_ready;
            if (accept) begin
               release_now = mux_last || (cnt_q == LAST_BEAT);
               m_valid_d   = 1'b1;
               m_data_d    = mux_data;
               m_last_d    = release_now;
               cnt_d       = cnt_q + 1'b1;
               if (release_now) begin
                  state_d = ST_IDLE;
                  ptr_d   = ~sel_q;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 1'b0;
         sel_q     <= 1'b0;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [STATS_W-1:0] g0_cnt_q, g1_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         g0_cnt_q <= '0;
         g1_cnt_q <= '0;
      end else begin
         if (grant0) g0_cnt_q <= sat_inc(g0_cnt_q);
         if (grant1) g1_cnt_q <= sat_inc(g1_cnt_q);
      end
   end

   assign grant0_cnt = g0_cnt_q;
   assign grant1_cnt = g1_cnt_q;
`endif

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_last    = m_last_q;
   assign sel       = sel_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit output bus between two requesters (s0, s1) using a valid/ready handshake.
- Owns the 2:1 select, grants whole bursts (delimited by `last`) and registers the selected beat onto the output.
- Sits between two 8-bit producers and a single downstream 8-bit consumer in the FPGA datapath.

Parameters:
- DATA_W, 8: data width of both sources and the output.
- MAX_BURST, 16: maximum beats per grant. Range 1..255. The beat counter is 8 bits.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- s0_valid  input  1  source 0 beat valid.
- s0_data  input  DATA_W  source 0 beat data.
- s0_last  input  1  source 0 final beat of burst.
- s0_ready  output  1  source 0 beat accepted this cycle when high with s0_valid.
- s1_valid, s1_data, s1_last, s1_ready: same as s0, for source 1.
- m_valid  output  1  output beat valid (registered).
- m_data  output  DATA_W  output beat data (registered).
- m_last  output  1  output final beat of grant (registered).
- m_ready  input  1  downstream accepts beat.
- sel  output  1  current owner: 0 = s0, 1 = s1. Registered.
- busy  output  1  high in OWN0/OWN1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk. reset has priority over every other event.
- Reset values:
  - State IDLE; priority pointer favours s0.
  - sel=0, busy=0.
  - m_valid=0, m_data=0, m_last=0.
  - s0_ready=0, s1_ready=0.
  - Beat count 0.
- States:
  - IDLE:
    - sX_ready=0.
    - If exactly one valid: go to OWN of that source.
    - If both valid: grant the source the pointer favours.
    - If none valid: stay in IDLE.
    - sel updates with the state. This costs a one-cycle arbitration bubble per grant.
  - OWN0 / OWN1:
    - owner_ready = !m_valid || m_ready. The non-owner's ready is 0.
    - Accepted beat (owner valid && owner ready): data and last are registered into m_*, m_valid=1 the next cycle (latency 1). Beat count increments.
    - Release condition: accepted beat with owner last=1, OR accepted beat is beat number MAX_BURST. On the MAX_BURST beat, m_last is forced to 1.
    - On release: next state IDLE, pointer favours the other source, beat count cleared.
    - Owner dropping valid mid-burst: ownership is held and no switch occurs.
- Output register:
  - m_valid clears when m_ready=1 and no new beat is accepted that cycle.
  - m_* is stable while m_valid && !m_ready.
  - Full throughput of 1 beat per cycle inside a burst when m_ready is held high.
- Boundary conditions:
  - Output stall: owner_ready=0 and no beats are lost.
  - Release and a new request in the same cycle: the new request is evaluated in IDLE on the following cycle.
  - Reset mid-burst: any in-flight m_* beat is discarded and the state returns to IDLE.
  - MAX_BURST=1: every beat is a separate grant. Sources alternate when both are valid.
  - Pointer wrap: the pointer toggles on every release, including timeout releases.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: adds outputs grant0_cnt and grant1_cnt (16 bits each).
  - Each counts grants issued (IDLE→OWNx transitions).
  - Saturates at 0xFFFF.
  - Cleared by reset.
- When undefined: these ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mux2_arb_pkg holds:
  - State encoding constants: ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Default DATA_W and MAX_BURST.
  - Stats counter width of 16.
- One natural sub-module: bus_sel2, a purely combinational DATA_W-wide 2:1 select of {data, last} driven by sel. It is instantiated once ahead of the output register.

Test Plan:
- Single requester: s0 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33) with m_ready=1 → sel=0, m_data 0x11/0x22/0x33 on consecutive cycles starting 2 cycles after s0_valid, m_last only on 0x33, back to IDLE.
- Contention: s0 and s1 both assert 2-beat bursts (0xA0/0xA1 and 0xB0/0xB1) from reset → order is A0, A1, B0, B1. Repeating both → next grant goes to s0 again, proving alternation.
- Backpressure: m_ready=0 for 4 cycles mid-burst → m_data held constant, owner s*_ready=0, no beat dropped or duplicated.
- Timeout with MAX_BURST=4: s1 streams 6 beats 0x01..0x06 with no last while s0 also requests → beat 0x04 has m_last=1, s0 granted next, s1 regranted afterwards for 0x05, 0x06.
- Reset mid-burst: assert reset for 1 cycle during s0 beat 2 → next cycle m_valid=0, sel=0, busy=0, ready=0. If ARB_STATS_EN is defined, grant counters read 0.
- ARB_STATS_EN: 5 alternating single-beat bursts (s0, s1, s0, s1, s0) → grant0_cnt=3, grant1_cnt=2.
